vga_rect_arbiter: RTL

//  Shares the single VGA pixel-write port (VGA_X/VGA_Y/VGA_COLOR/plot) among NREQ drawing

---
 rtl/vga_draw_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/vga_rect_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_draw_pkg.sv
// ============================================================================
// Module      : vga_draw_pkg
// Description : Shared frame geometry, colour codes and draw FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_draw_pkg;

    localparam int XRES = 160;
    localparam int YRES = 120;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] BLUE   = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first set request at or after
//               the pointer, wrapping modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_valid
);

    logic [PW:0] w_sum;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            if (!o_valid && i_req[w_sum[PW-1:0]]) begin
                o_valid                 = 1'b1;
                o_idx                   = w_sum[PW-1:0];
                o_grant[w_sum[PW-1:0]] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_rect_arbiter.sv
// ============================================================================
// Module      : vga_rect_arbiter
// Description : Round-robin shares the VGA pixel port among NREQ rectangle
//               fill engines, scanning each rectangle row-major with clipping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_rect_arbiter #(
    parameter int NREQ = 3,
    parameter int XRES = vga_draw_pkg::XRES,
    parameter int YRES = vga_draw_pkg::YRES
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_x,
    input  logic [NREQ*7-1:0] req_y,
    input  logic [NREQ*8-1:0] req_w,
    input  logic [NREQ*7-1:0] req_h,
    input  logic [NREQ*3-1:0] req_color,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [7:0]        VGA_X,
    output logic [6:0]        VGA_Y,
    output logic [2:0]        VGA_COLOR,
    output logic              plot
);

    import vga_draw_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    draw_state_t     r_state;
    draw_state_t     w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;

    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_gidx;
    logic            w_gvalid;

    logic [7:0]      w_sx;
    logic [6:0]      w_sy;
    logic [7:0]      w_sw;
    logic [6:0]      w_sh;
    logic [2:0]      w_sc;

    logic [7:0]      r_x0;
    logic [6:0]      r_y0;
    logic [7:0]      r_w;
    logic [6:0]      r_h;
    logic [2:0]      r_col;
    logic            r_empty;
    logic [NREQ-1:0] r_gnt;
    logic [7:0]      r_cx;
    logic [6:0]      r_cy;

    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] r_done;
    logic            r_busy;
    logic            r_plot;
    logic [7:0]      r_vx;
    logic [6:0]      r_vy;
    logic [2:0]      r_vc;

    logic            w_ld;
    logic            w_emit;
    logic [NREQ-1:0] w_ack_nxt;
    logic [NREQ-1:0] w_done_nxt;
    logic [7:0]      w_base_x;
    logic [6:0]      w_base_y;
    logic [7:0]      w_cx_nxt;
    logic [6:0]      w_cy_nxt;
    logic [2:0]      w_col_nxt;
    logic            w_row_end;
    logic            w_last_row;
    logic [8:0]      w_sum_x;
    logic [7:0]      w_sum_y;
    logic            w_plot_nxt;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_gidx),
        .o_valid (w_gvalid)
    );

    assign w_sx = req_x[w_gidx*8 +: 8];
    assign w_sy = req_y[w_gidx*7 +: 7];
    assign w_sw = req_w[w_gidx*8 +: 8];
    assign w_sh = req_h[w_gidx*7 +: 7];
    assign w_sc = req_color[w_gidx*3 +: 3];

    assign w_row_end  = (r_cx == r_w - 8'd1);
    assign w_last_row = (r_cy == r_h - 7'd1);

    // Next-state plus the pixel slot the output registers will present next cycle
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ld        = 1'b0;
        w_emit      = 1'b0;
        w_ack_nxt   = '0;
        w_done_nxt  = '0;
        w_base_x    = r_x0;
        w_base_y    = r_y0;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        w_col_nxt   = r_col;
        case (r_state)
            IDLE: begin
                if (w_gvalid) begin
                    w_state_nxt = DRAW;
                    w_ld        = 1'b1;
                    w_ptr_nxt   = (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + PW'(1);
                    w_ack_nxt   = w_gnt;
                    w_emit      = (w_sw != 8'd0) && (w_sh != 7'd0);
                    w_base_x    = w_sx;
                    w_base_y    = w_sy;
                    w_cx_nxt    = '0;
                    w_cy_nxt    = '0;
                    w_col_nxt   = w_sc;
                end
            end
            DRAW: begin
                if (r_empty || (w_row_end && w_last_row)) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = r_gnt;
                end else begin
                    w_emit = 1'b1;
                    if (w_row_end) begin
                        w_cx_nxt = '0;
                        w_cy_nxt = r_cy + 7'd1;
                    end else begin
                        w_cx_nxt = r_cx + 8'd1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sums are one bit wider so an off-frame pixel never aliases back on screen
    assign w_sum_x    = {1'b0, w_base_x} + {1'b0, w_cx_nxt};
    assign w_sum_y    = {1'b0, w_base_y} + {1'b0, w_cy_nxt};
    assign w_plot_nxt = w_emit && (w_sum_x < 9'(XRES)) && (w_sum_y < 8'(YRES));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_col   <= '0;
            r_empty <= 1'b0;
            r_gnt   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_ack   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_plot  <= 1'b0;
            r_vx    <= '0;
            r_vy    <= '0;
            r_vc    <= '0;
        end else begin
            if (w_ld) begin
                r_x0    <= w_sx;
                r_y0    <= w_sy;
                r_w     <= w_sw;
                r_h     <= w_sh;
                r_col   <= w_sc;
                r_empty <= (w_sw == 8'd0) || (w_sh == 7'd0);
                r_gnt   <= w_gnt;
            end
            r_cx   <= w_cx_nxt;
            r_cy   <= w_cy_nxt;
            r_ack  <= w_ack_nxt;
            r_done <= w_done_nxt;
            r_busy <= (w_state_nxt != IDLE);
            r_plot <= w_plot_nxt;
            if (w_emit) begin
                r_vx <= w_sum_x[7:0];
                r_vy <= w_sum_y[6:0];
                r_vc <= w_col_nxt;
            end
        end
    end

    assign ack       = r_ack;
    assign done      = r_done;
    assign busy      = r_busy;
    assign plot      = r_plot;
    assign VGA_X     = r_vx;
    assign VGA_Y     = r_vy;
    assign VGA_COLOR = r_vc;

endmodule

`default_nettype wire
